// File: rtl/stack_mem_arbiter_if.sv
// Bus bundle between the stack processor, the loader/debug port and the shared
// single-ported memory. The arbiter connects through the slave modport.
interface stack_mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              cpu_done;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, cpu_done,
        output ext_rdata, ext_ack,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, cpu_done,
        input  ext_rdata, ext_ack,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/stack_mem_arbiter.sv
// Shares the stack processor's single-ported memory between the CPU and EXT ports.
// Define ARB_RR_EN for round-robin tie breaking; default build is fixed CPU priority.
module stack_mem_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    stack_mem_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              owner_r;
    logic              we_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              cpu_req_s;
    logic              ext_req_s;
    logic              grant_ext_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              accept_s;
    logic              capture_s;

    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] ext_rdata_r;
    logic              cpu_done_r;
    logic              ext_ack_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              mem_we_r;
    logic              mem_re_r;

`ifdef ARB_RR_EN
    logic              last_owner_r;
`endif

    // Request decode and grant selection; a CPU request with both rd and wr is a write.
    always_comb begin
        cpu_req_s   = bus.cpu_rd | bus.cpu_wr;
        ext_req_s   = bus.ext_req;
        grant_ext_s = 1'b0;
`ifdef ARB_RR_EN
        if (cpu_req_s && ext_req_s) begin
            grant_ext_s = (last_owner_r == OWN_CPU);
        end else if (ext_req_s) begin
            grant_ext_s = 1'b1;
        end else begin
            grant_ext_s = 1'b0;
        end
`else
        if (cpu_req_s) begin
            grant_ext_s = 1'b0;
        end else if (ext_req_s) begin
            grant_ext_s = 1'b1;
        end else begin
            grant_ext_s = 1'b0;
        end
`endif
        if (grant_ext_s) begin
            sel_we_s    = bus.ext_we;
            sel_addr_s  = bus.ext_addr;
            sel_wdata_s = bus.ext_wdata;
        end else begin
            sel_we_s    = bus.cpu_wr;
            sel_addr_s  = bus.cpu_addr;
            sel_wdata_s = bus.cpu_wdata;
        end
    end

    // Next-state logic of the access sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req_s || ext_req_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (we_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Transaction acceptance and read-data capture qualifiers.
    always_comb begin
        accept_s  = (state_r == ST_IDLE) && (state_s == ST_ISSUE);
        capture_s = (state_r == ST_WAIT) && (cnt_r == CNT_LAST);
    end

    // State register, latched transaction attributes and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            owner_r <= OWN_CPU;
            we_r    <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                owner_r <= grant_ext_s;
                we_r    <= sel_we_s;
            end
            if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= '0;
            end
        end
    end

`ifdef ARB_RR_EN
    // Last grant owner; starts as EXT so the CPU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_r <= OWN_EXT;
        end else if (accept_s) begin
            last_owner_r <= grant_ext_s;
        end
    end
`endif

    // Memory strobes are only asserted for the single ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we_r    <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            mem_we_r    <= accept_s & sel_we_s;
            mem_re_r    <= accept_s & ~sel_we_s;
            mem_addr_r  <= accept_s ? sel_addr_s : '0;
            mem_wdata_r <= (accept_s && sel_we_s) ? sel_wdata_s : '0;
        end
    end

    // Completion pulses and per-owner read data; the non-owner's rdata is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_done_r  <= 1'b0;
            ext_ack_r   <= 1'b0;
            cpu_rdata_r <= '0;
            ext_rdata_r <= '0;
        end else begin
            cpu_done_r <= (state_s == ST_DONE) && (owner_r == OWN_CPU);
            ext_ack_r  <= (state_s == ST_DONE) && (owner_r == OWN_EXT);
            if (capture_s && (owner_r == OWN_CPU)) begin
                cpu_rdata_r <= bus.mem_rdata;
            end
            if (capture_s && (owner_r == OWN_EXT)) begin
                ext_rdata_r <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.cpu_done  = cpu_done_r;
    assign bus.cpu_stall = cpu_req_s & ~cpu_done_r;
    assign bus.ext_rdata = ext_rdata_r;
    assign bus.ext_ack   = ext_ack_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_re    = mem_re_r;

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Self-checking bench for stack_mem_arbiter: one MEM_LAT=1 and one MEM_LAT=3 instance,
// each with a latency-accurate memory, checked against an array-level reference model.
`timescale 1ns/1ps
module tb_stack_mem_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;
    localparam bit P_CPU = 1'b0;
    localparam bit P_EXT = 1'b1;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic mem_load;
    always #5 clk = ~clk;

    stack_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    stack_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    stack_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    stack_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    // Physical memories: data valid MEM_LAT cycles after the read strobe, garbage otherwise.
    logic [DW-1:0] seed_mem [32];
    logic [DW-1:0] mem1 [32];
    logic [DW-1:0] mem3 [32];
    logic [DW-1:0] pipe1;
    logic [DW-1:0] pipe3 [3];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) mem1[i] <= seed_mem[i];
        end else if (bus.mem_we) begin
            mem1[bus.mem_addr] <= bus.mem_wdata;
        end
        pipe1 <= bus.mem_re ? mem1[bus.mem_addr] : DW'($urandom);
    end
    assign bus.mem_rdata = pipe1;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) mem3[i] <= seed_mem[i];
        end else if (bus3.mem_we) begin
            mem3[bus3.mem_addr] <= bus3.mem_wdata;
        end
        pipe3[0] <= bus3.mem_re ? mem3[bus3.mem_addr] : DW'($urandom);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bus3.mem_rdata = pipe3[2];

    // Reference model: memory contents, each port's last read result, last grant owner.
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] ref_cpu_rd;
    logic [DW-1:0] ref_ext_rd;
    bit            ref_last;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_complete(input bit port, input bit we,
                                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (we) ref_mem[addr] = wd;
        else if (port == P_CPU) ref_cpu_rd = ref_mem[addr];
        else ref_ext_rd = ref_mem[addr];
        ref_last = port;
    endfunction

    function automatic int lat_of(input bit we);
        return we ? 3 : 3 + LAT;
    endfunction

    task automatic drive_cpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit both);
        bus.cpu_rd = !we || both;
        bus.cpu_wr = we;
        bus.cpu_addr = a;
        bus.cpu_wdata = d;
    endtask

    task automatic drive_ext(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ext_req = 1'b1;
        bus.ext_we = we;
        bus.ext_addr = a;
        bus.ext_wdata = d;
    endtask

    // Single access with the arbiter idle; called and returns at a negedge.
    task automatic do_access(input bit port, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input bit both);
        int exp_lat, done_cyc, cyc;
        logic dn, xdn;
        exp_lat = lat_of(we);
        if (port == P_CPU) drive_cpu(we, addr, wd, both);
        else drive_ext(we, addr, wd);
        #1;
        check("stall_c1", 32'(bus.cpu_stall), 32'(port == P_CPU));
        done_cyc = 0;
        cyc = 1;
        while (done_cyc == 0 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            dn  = port ? bus.ext_ack : bus.cpu_done;
            xdn = port ? bus.cpu_done : bus.ext_ack;
            if (cyc == 2) begin
                check("issue_we", 32'(bus.mem_we), 32'(we));
                check("issue_re", 32'(bus.mem_re), 32'(!we));
                check("issue_addr", 32'(bus.mem_addr), 32'(addr));
                if (we) check("issue_wdata", 32'(bus.mem_wdata), 32'(wd));
            end else begin
                check("strobe_quiet", 32'({bus.mem_we, bus.mem_re}), 32'(0));
            end
            check("other_quiet", 32'(xdn), 32'(0));
            check("stall", 32'(bus.cpu_stall), 32'((port == P_CPU) && (cyc != exp_lat)));
            if (dn) done_cyc = cyc;
        end
        check("latency", done_cyc, exp_lat);
        model_complete(port, we, addr, wd);
        check("cpu_rdata", 32'(bus.cpu_rdata), 32'(ref_cpu_rd));
        check("ext_rdata", 32'(bus.ext_rdata), 32'(ref_ext_rd));
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        bus.ext_req = 1'b0;
        @(negedge clk);
        check("pulse_width", 32'({bus.cpu_done, bus.ext_ack}), 32'(0));
    endtask

    // Both ports request in the same cycle; each drops its request on its own completion.
    task automatic do_contend(input bit cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                              input bit ewe, input logic [AW-1:0] ea, input logic [DW-1:0] ewd);
        bit first, cpu_held;
        int exp_c, exp_e, got_c, got_e, cyc;
        first = (RR && ref_last == P_CPU) ? P_EXT : P_CPU;
        if (first == P_CPU) begin
            exp_c = lat_of(cwe);
            exp_e = exp_c + lat_of(ewe);
        end else begin
            exp_e = lat_of(ewe);
            exp_c = exp_e + lat_of(cwe);
        end
        drive_cpu(cwe, ca, cwd, cwe);
        drive_ext(ewe, ea, ewd);
        cpu_held = 1'b1;
        #1;
        check("cont_stall_c1", 32'(bus.cpu_stall), 32'(1));
        got_c = 0;
        got_e = 0;
        cyc = 1;
        while ((got_c == 0 || got_e == 0) && cyc < 30) begin
            @(negedge clk);
            cyc++;
            check("cont_stall", 32'(bus.cpu_stall), 32'(cpu_held && (cyc != exp_c)));
            check("cont_excl", 32'(bus.mem_we & bus.mem_re), 32'(0));
            if (bus.cpu_done) begin
                got_c = cyc;
                model_complete(P_CPU, cwe, ca, cwd);
                check("cont_cpu_rdata", 32'(bus.cpu_rdata), 32'(ref_cpu_rd));
                bus.cpu_rd = 1'b0;
                bus.cpu_wr = 1'b0;
                cpu_held = 1'b0;
            end
            if (bus.ext_ack) begin
                got_e = cyc;
                model_complete(P_EXT, ewe, ea, ewd);
                check("cont_ext_rdata", 32'(bus.ext_rdata), 32'(ref_ext_rd));
                bus.ext_req = 1'b0;
            end
        end
        check("cont_cpu_done_cyc", got_c, exp_c);
        check("cont_ext_ack_cyc", got_e, exp_e);
        ref_last = (first == P_CPU) ? P_EXT : P_CPU;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
        bus.ext_req = 1'b0;
        @(negedge clk);
        check("cont_pulse_width", 32'({bus.cpu_done, bus.ext_ack}), 32'(0));
    endtask

    // Both ports read continuously until n completions have been seen.
    task automatic do_stream(input int n, input logic [AW-1:0] ca, input logic [AW-1:0] ea);
        int lat, idx, cyc;
        bit own, exp_own;
        lat = lat_of(1'b0);
        drive_cpu(1'b0, ca, '0, 1'b0);
        drive_ext(1'b0, ea, '0);
        idx = 0;
        cyc = 1;
        while (idx < n && cyc < n * lat + 10) begin
            @(negedge clk);
            cyc++;
            if (bus.cpu_done || bus.ext_ack) begin
                idx++;
                own = bus.ext_ack;
                exp_own = (RR && ref_last == P_CPU) ? P_EXT : P_CPU;
                check("stream_owner", 32'(own), 32'(exp_own));
                check("stream_single", 32'(bus.cpu_done & bus.ext_ack), 32'(0));
                check("stream_cycle", cyc, idx * lat);
                model_complete(exp_own, 1'b0, exp_own ? ea : ca, '0);
                check("stream_rdata", exp_own ? 32'(bus.ext_rdata) : 32'(bus.cpu_rdata),
                      exp_own ? 32'(ref_ext_rd) : 32'(ref_cpu_rd));
            end
        end
        check("stream_count", idx, n);
        bus.cpu_rd = 1'b0;
        bus.ext_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] wd;
        int re_cyc, dn_cyc;
        rst = 1'b1;
        mem_load = 1'b1;
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
        bus3.cpu_rd = 1'b0; bus3.cpu_wr = 1'b0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
        bus3.ext_req = 1'b0; bus3.ext_we = 1'b0; bus3.ext_addr = '0; bus3.ext_wdata = '0;
        for (int i = 0; i < 32; i++) seed_mem[i] = DW'($urandom);
        seed_mem[4] = 8'hA5;
        seed_mem[7] = 8'h5A;
        for (int i = 0; i < 32; i++) ref_mem[i] = seed_mem[i];
        ref_cpu_rd = '0;
        ref_ext_rd = '0;
        ref_last = P_EXT;

        @(negedge clk);
        @(negedge clk);
        check("rst_outputs", 32'({bus.cpu_rdata, bus.ext_rdata, bus.cpu_done, bus.ext_ack,
                                  bus.mem_we, bus.mem_re, bus.cpu_stall}), 32'(0));
        check("rst_mem_bus", 32'({bus.mem_addr, bus.mem_wdata}), 32'(0));
        check("rst_outputs3", 32'({bus3.cpu_rdata, bus3.cpu_done, bus3.mem_re}), 32'(0));
        mem_load = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed: read 0x04, write 0x1F, read it back, same-cycle contention.
        do_access(P_CPU, 1'b0, 5'h04, 8'h00, 1'b0);
        check("read_a5", 32'(bus.cpu_rdata), 32'(8'hA5));
        do_access(P_CPU, 1'b1, 5'h1F, 8'h3C, 1'b0);
        do_access(P_CPU, 1'b0, 5'h1F, 8'h00, 1'b0);
        check("readback_3c", 32'(bus.cpu_rdata), 32'(8'h3C));
        do_contend(1'b0, 5'h04, 8'h00, 1'b0, 5'h1F, 8'h00);
        do_access(P_EXT, 1'b1, 5'h09, 8'hC3, 1'b0);
        do_access(P_EXT, 1'b0, 5'h09, 8'h00, 1'b0);

        // MEM_LAT=3 instance: read 0x07.
        bus3.cpu_rd = 1'b1;
        bus3.cpu_addr = 5'h07;
        re_cyc = 0;
        dn_cyc = 0;
        for (int cyc = 2; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (bus3.mem_re && re_cyc == 0) re_cyc = cyc;
            if (bus3.cpu_done && dn_cyc == 0) dn_cyc = cyc;
            if (cyc == 5) check("lat3_not_early", 32'(bus3.cpu_rdata), 32'(0));
            if (cyc == 6) begin
                check("lat3_rdata", 32'(bus3.cpu_rdata), 32'(8'h5A));
                bus3.cpu_rd = 1'b0;
            end
        end
        check("lat3_re_cyc", re_cyc, 2);
        check("lat3_done_cyc", dn_cyc, 6);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_contend(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                           1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            end else begin
                do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        do_stream(6, 5'h04, 5'h1F);

        // Reset during the ISSUE cycle of a CPU write to 0x03.
        wd = ~ref_mem[3];
        drive_cpu(1'b1, 5'h03, wd, 1'b0);
        @(negedge clk);
        check("rst_pre_we", 32'(bus.mem_we), 32'(1));
        rst = 1'b1;
        #1;
        check("rst_we_drop", 32'({bus.mem_we, bus.mem_re}), 32'(0));
        check("rst_no_done", 32'(bus.cpu_done), 32'(0));
        bus.cpu_wr = 1'b0;
        @(negedge clk);
        check("rst_hold_outputs", 32'({bus.cpu_rdata, bus.ext_rdata, bus.cpu_done, bus.ext_ack,
                                       bus.cpu_stall}), 32'(0));
        rst = 1'b0;
        ref_cpu_rd = '0;
        ref_ext_rd = '0;
        ref_last = P_EXT;
        @(negedge clk);
        check("rst_post_outputs", 32'({bus.cpu_rdata, bus.ext_rdata, bus.cpu_done, bus.ext_ack,
                                       bus.mem_we, bus.mem_re}), 32'(0));
        do_access(P_CPU, 1'b0, 5'h03, 8'h00, 1'b0);
        do_contend(1'b0, 5'h03, 8'h00, 1'b0, 5'h04, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget, checks %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule

// File: doc/stack_mem_arbiter.md
Name: stack_mem_arbiter

Overview:
- Shares the single-ported instruction/data memory of the multi-cycle stack processor between the processor datapath (CPU port) and an external loader/debug port (EXT port).
- Arbitrates, sequences each access through a fixed-latency memory, and returns read data.
- Stalls the processor controller until its access completes, so memory wait states and loader traffic are invisible to the instruction FSM.

Parameters:
- ADDR_W, 5, address width (5-bit operand field of the 8-bit instruction).
- DATA_W, 8, data word width.
- MEM_LAT, 1, memory read latency in cycles (must be ≥1). Read data is valid MEM_LAT cycles after the issue cycle.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_rd  in  1  CPU read request (maps to mem_read).
- cpu_wr  in  1  CPU write request (maps to mem_write).
- cpu_addr  in  ADDR_W  CPU address (PC or IR operand, selected by IorD).
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  registered read data for the CPU.
- cpu_stall  out  1  high while a CPU request is pending and not yet done; controller holds its state.
- cpu_done  out  1  one-cycle completion pulse for the CPU access.
- ext_req  in  1  EXT access request.
- ext_we  in  1  EXT write (1) or read (0).
- ext_addr  in  ADDR_W  EXT address.
- ext_wdata  in  DATA_W  EXT write data.
- ext_rdata  out  DATA_W  registered read data for EXT.
- ext_ack  out  1  one-cycle completion pulse for EXT.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe, one cycle.
- mem_re  out  1  memory read strobe, one cycle.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (async, any state): FSM goes to IDLE.
  - All outputs 0; cpu_rdata and ext_rdata are cleared to 0.
  - mem_we and mem_re drop immediately, so an in-flight access is aborted with no done/ack.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is present, latch the winner (owner, address, wdata, r/w) and go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration (default): fixed priority, CPU over EXT. A CPU request is cpu_rd|cpu_wr.
- CPU with both cpu_rd and cpu_wr high is treated as a write.
- ISSUE (1 cycle): drive mem_addr/mem_wdata from the latched values; assert mem_we (write) or mem_re (read).
  - Write: go to DONE.
  - Read: go to WAIT.
- WAIT: lasts MEM_LAT cycles, counted from the cycle after ISSUE.
  - On the last WAIT cycle, mem_rdata is captured into the owner's rdata register.
  - Then go to DONE.
  - Counter width is clog2(MEM_LAT+1).
- DONE (1 cycle): pulse cpu_done or ext_ack for the owner, then return to IDLE. The non-owner's rdata is unchanged.
- Latency from request to done/ack, with the arbiter idle:
  - Write: 3 cycles (IDLE, ISSUE, DONE).
  - Read: 3+MEM_LAT cycles.
- cpu_stall = (cpu_rd|cpu_wr) & ~cpu_done. It is combinational and is high while EXT owns memory.
- Requesters hold request, address and data stable until done/ack.
  - Inputs are latched in IDLE, so later changes do not affect the current access.
  - A request dropped mid-transaction still completes and still pulses done/ack.
- Back-to-back: DONE always returns to IDLE. There is one re-arbitration cycle per access, so no combinational done→issue path exists.
- mem_we/mem_re are never high together and are never high outside ISSUE.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last-owner flop (reset value EXT, so the CPU wins the first tie) gives the tie to the port that did not own the previous grant.
  - Single requesters are always granted.
  - Bounds EXT starvation to one CPU access.
- Undefined: fixed CPU priority as above; the last-owner flop is not implemented.

Test Plan:
- Reset: assert rst mid-ISSUE of a CPU write to 0x03 → mem_we drops same cycle, no cpu_done; after release all outputs are 0 and FSM is IDLE.
- CPU read, MEM_LAT=1: memory holds 0xA5 at 0x04; cpu_rd, addr 0x04 → mem_re in cycle 2, cpu_done in cycle 4, cpu_rdata=0xA5, cpu_stall high cycles 1-3.
- CPU write: cpu_wr, addr 0x1F, data 0x3C → mem_we with addr 0x1F/data 0x3C in cycle 2, cpu_done in cycle 3; a later read of 0x1F returns 0x3C.
- Contention, fixed priority: cpu_rd and ext_req (read) raised in the same cycle → CPU served first; ext_ack arrives after the CPU read, with ext_rdata equal to memory and cpu_stall unaffected by EXT.
- With ARB_RR_EN, CPU and EXT request continuously → grants alternate CPU, EXT, CPU, EXT; without it → EXT never acked while the CPU keeps requesting.
- MEM_LAT=3 read of 0x07 holding 0x5A → mem_re in cycle 2, rdata captured in cycle 5, cpu_done in cycle 6, cpu_rdata=0x5A.
